// File: rtl/ps2_host_rx.sv
// +----------------------------------------------------------------------------+
// | Module  : ps2_host_rx                                                      |
// | Purpose : PS/2 device->host frame receiver with byte FIFO (FWFT).          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module ps2_host_rx #(
    parameter int FIFO_BITS = 3,
    parameter int FILTER    = 8,
    parameter int TIMEOUT   = 100000
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    input  logic                 rd,
    output logic [7:0]           dout,
    output logic                 empty,
    output logic [FIFO_BITS:0]   count,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overflow
);

    localparam int                          c_DEPTH      = 1 << FIFO_BITS;
    localparam int                          c_TIMER_W    = $clog2(TIMEOUT + 1);
    localparam logic [7:0]                  c_FILT_LAST  = 8'(FILTER - 1);
    localparam logic [c_TIMER_W-1:0]        c_TIMER_LAST = c_TIMER_W'(TIMEOUT - 1);
    localparam logic [FIFO_BITS:0]          c_FULL       = (FIFO_BITS+1)'(c_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic                   r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic                   r_filt_clk;
    logic [7:0]             r_filt_cnt;
    logic [c_TIMER_W-1:0]   r_timer;
    state_t                 r_state, w_state_nx;
    logic [7:0]             r_shift, w_shift_nx;
    logic [2:0]             r_bitcnt, w_bitcnt_nx;
    logic                   r_par, w_par_nx;
    logic                   w_push, w_perr, w_ferr, w_timeout, w_bit_event;
    logic                   r_push_req;
    logic [7:0]             r_push_byte;

    logic [7:0]             r_mem [c_DEPTH];
    logic [FIFO_BITS-1:0]   r_wptr, r_rptr;
    logic [FIFO_BITS:0]     r_count;
    logic                   w_full, w_pop, w_wr, w_ovf;

    // Filtered clock flips only after FILTER consecutive differing samples
    assign w_bit_event = r_filt_clk && !r_clk_s2 && (r_filt_cnt == c_FILT_LAST);
    assign w_timeout   = (r_state != S_IDLE) && (r_timer == c_TIMER_LAST);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_filt_clk <= 1'b1;
            r_filt_cnt <= 8'd0;
            r_timer    <= '0;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
            if (r_clk_s2 == r_filt_clk) begin
                r_filt_cnt <= 8'd0;
            end else if (r_filt_cnt == c_FILT_LAST) begin
                r_filt_clk <= r_clk_s2;
                r_filt_cnt <= 8'd0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 8'd1;
            end
            if (w_bit_event || w_timeout || r_state == S_IDLE) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_shift     <= 8'd0;
            r_bitcnt    <= 3'd0;
            r_par       <= 1'b0;
            r_push_req  <= 1'b0;
            r_push_byte <= 8'd0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_shift     <= w_shift_nx;
            r_bitcnt    <= w_bitcnt_nx;
            r_par       <= w_par_nx;
            r_push_req  <= w_push;
            r_push_byte <= r_shift;
            parity_err  <= w_perr;
            frame_err   <= w_ferr;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_shift_nx  = r_shift;
        w_bitcnt_nx = r_bitcnt;
        w_par_nx    = r_par;
        w_push      = 1'b0;
        w_perr      = 1'b0;
        w_ferr      = 1'b0;
        if (w_bit_event) begin
            case (r_state)
                S_IDLE: begin
                    if (!r_dat_s2) begin
                        w_state_nx  = S_DATA;
                        w_bitcnt_nx = 3'd0;
                    end else begin
                        w_ferr = 1'b1;
                    end
                end
                S_DATA: begin
                    w_shift_nx  = {r_dat_s2, r_shift[7:1]};
                    w_bitcnt_nx = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        w_state_nx = S_PARITY;
                    end
                end
                S_PARITY: begin
                    w_par_nx   = r_dat_s2;
                    w_state_nx = S_STOP;
                end
                default: begin
                    // Stop-bit error outranks parity error: one pulse per frame
                    w_state_nx = S_IDLE;
                    if (!r_dat_s2) begin
                        w_ferr = 1'b1;
                    end else if (!(^{r_shift, r_par})) begin
                        w_perr = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
                end
            endcase
        end else if (w_timeout) begin
            w_state_nx = S_IDLE;
            w_ferr     = 1'b1;
        end
    end

    assign w_full = (r_count == c_FULL);
    assign w_pop  = rd && (r_count != '0);
    assign w_wr   = r_push_req && (!w_full || w_pop);
    assign w_ovf  = r_push_req && w_full && !w_pop;

    always_ff @(posedge clk_sys) begin
        if (w_wr) begin
            r_mem[r_wptr] <= r_push_byte;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= w_ovf;
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head is masked while empty so the memory needs no reset
    assign dout  = (r_count == '0) ? 8'h00 : r_mem[r_rptr];
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_rx.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_ps2_host_rx                                                   |
// | Purpose : Directed self-checking bench for ps2_host_rx.                    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ps2_host_rx;

    localparam int FIFO_BITS = 3;
    localparam int FILTER    = 8;
    localparam int TIMEOUT   = 3000;
    localparam int HALF      = 80;

    logic                clk_sys = 1'b0;
    logic                reset   = 1'b1;
    logic                ps2_clk = 1'b1;
    logic                ps2_data = 1'b1;
    logic                rd      = 1'b0;
    logic [7:0]          dout;
    logic                empty;
    logic [FIFO_BITS:0]  count;
    logic                parity_err, frame_err, overflow;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int n_perr = 0, n_ferr = 0, n_ovf = 0;
    int t_fall = 0, t_ferr = 0;

    ps2_host_rx #(.FIFO_BITS(FIFO_BITS), .FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rd         (rd),
        .dout       (dout),
        .empty      (empty),
        .count      (count),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (parity_err) n_perr++;
        if (frame_err) begin
            n_ferr++;
            t_ferr = cyc;
        end
        if (overflow) n_ovf++;
    end

    task automatic clear_counts();
        n_perr = 0;
        n_ferr = 0;
        n_ovf  = 0;
    endtask

    task automatic drive_bit(input logic b, input int half);
        ps2_data = b;
        repeat (half) @(negedge clk_sys);
        ps2_clk = 1'b0;
        t_fall  = cyc;
        repeat (half) @(negedge clk_sys);
        ps2_clk = 1'b1;
    endtask

    // nbits < 11 sends a truncated frame; rd_on_push raises rd in the push cycle
    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop,
                              input int half, input int nbits, input logic rd_on_push);
        logic [10:0] f;
        f = {stop, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            if (i == 10 && rd_on_push) begin
                ps2_data = f[10];
                repeat (half) @(negedge clk_sys);
                ps2_clk = 1'b0;
                t_fall  = cyc;
                repeat (FILTER + 2) @(negedge clk_sys);
                rd = 1'b1;
                @(negedge clk_sys);
                rd = 1'b0;
                repeat (half - FILTER - 3) @(negedge clk_sys);
                ps2_clk = 1'b1;
            end else begin
                drive_bit(f[i], half);
            end
        end
        ps2_data = 1'b1;
        repeat (20) @(negedge clk_sys);
    endtask

    task automatic pop();
        rd = 1'b1;
        @(negedge clk_sys);
        rd = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", dout); end
        checks++;
        if ({parity_err, frame_err, overflow} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses: got %b expected 000", {parity_err, frame_err, overflow});
        end
    endtask

    task automatic test_single();
        clear_counts();
        send_frame(8'h1C, 1'b0, 1'b1, 1000, 11, 1'b0);
        checks++; if (dout !== 8'h1C) begin errors++; $display("FAIL single_dout: got %h expected 1c", dout); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty: got %b expected 0", empty); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
        checks++;
        if (n_perr + n_ferr + n_ovf != 0) begin
            errors++; $display("FAIL single_errs: got %0d expected 0", n_perr + n_ferr + n_ovf);
        end
        pop();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_pop_empty: got %b expected 1", empty); end
    endtask

    task automatic test_sequence();
        logic [7:0] exp [3];
        exp[0] = 8'hF0; exp[1] = 8'hE0; exp[2] = 8'h12;
        for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b0, 1'b1, HALF, 11, 1'b0);
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL seq_count: got %0d expected 3", count); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dout !== exp[i]) begin errors++; $display("FAIL seq_dout%0d: got %h expected %h", i, dout, exp[i]); end
            pop();
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL seq_empty: got %b expected 1", empty); end
    endtask

    task automatic test_parity();
        clear_counts();
        send_frame(8'h55, 1'b1, 1'b1, HALF, 11, 1'b0);
        checks++; if (n_perr != 1) begin errors++; $display("FAIL parity_pulse: got %0d expected 1", n_perr); end
        checks++; if (n_ferr != 0) begin errors++; $display("FAIL parity_ferr: got %0d expected 0", n_ferr); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL parity_count: got %0d expected 0", count); end
    endtask

    task automatic test_stop_err();
        clear_counts();
        send_frame(8'hAA, 1'b0, 1'b0, HALF, 11, 1'b0);
        checks++; if (n_ferr != 1) begin errors++; $display("FAIL stop_ferr: got %0d expected 1", n_ferr); end
        checks++; if (n_perr != 0) begin errors++; $display("FAIL stop_perr: got %0d expected 0", n_perr); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL stop_count: got %0d expected 0", count); end
        send_frame(8'h3C, 1'b0, 1'b1, HALF, 11, 1'b0);
        checks++; if (dout !== 8'h3C) begin errors++; $display("FAIL stop_next_dout: got %h expected 3c", dout); end
        pop();
    endtask

    task automatic test_timeout();
        clear_counts();
        send_frame(8'hC5, 1'b0, 1'b1, HALF, 5, 1'b0);
        repeat (TIMEOUT + 50) @(negedge clk_sys);
        checks++; if (n_ferr != 1) begin errors++; $display("FAIL timeout_ferr: got %0d expected 1", n_ferr); end
        checks++;
        if (t_ferr - t_fall != TIMEOUT + FILTER + 2) begin
            errors++; $display("FAIL timeout_time: got %0d expected %0d", t_ferr - t_fall, TIMEOUT + FILTER + 2);
        end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL timeout_count: got %0d expected 0", count); end
        send_frame(8'h3A, 1'b0, 1'b1, HALF, 11, 1'b0);
        checks++; if (dout !== 8'h3A) begin errors++; $display("FAIL timeout_next_dout: got %h expected 3a", dout); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL timeout_next_count: got %0d expected 1", count); end
        pop();
    endtask

    task automatic test_overflow();
        clear_counts();
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b1, HALF, 11, 1'b0);
        send_frame(8'h99, 1'b0, 1'b1, HALF, 11, 1'b0);
        checks++; if (n_ovf != 1) begin errors++; $display("FAIL ovf_pulse: got %0d expected 1", n_ovf); end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", count); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dout !== 8'h10 + 8'(i)) begin errors++; $display("FAIL ovf_dout%0d: got %h expected %h", i, dout, 8'h10 + 8'(i)); end
            pop();
        end
        clear_counts();
        for (int i = 0; i < 8; i++) send_frame(8'h20 + 8'(i), 1'b0, 1'b1, HALF, 11, 1'b0);
        send_frame(8'h77, 1'b0, 1'b1, HALF, 11, 1'b1);
        checks++; if (n_ovf != 0) begin errors++; $display("FAIL ovfrd_pulse: got %0d expected 0", n_ovf); end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovfrd_count: got %0d expected 8", count); end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] e;
            e = (i == 7) ? 8'h77 : 8'h21 + 8'(i);
            checks++;
            if (dout !== e) begin errors++; $display("FAIL ovfrd_dout%0d: got %h expected %h", i, dout, e); end
            pop();
        end
    endtask

    task automatic test_glitch();
        clear_counts();
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk_sys);
        ps2_clk = 1'b1;
        repeat (30) @(negedge clk_sys);
        checks++; if (n_ferr != 0) begin errors++; $display("FAIL glitch_ferr: got %0d expected 0", n_ferr); end
        send_frame(8'h5A, 1'b0, 1'b1, HALF, 11, 1'b0);
        checks++; if (dout !== 8'h5A) begin errors++; $display("FAIL glitch_dout: got %h expected 5a", dout); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL glitch_count: got %0d expected 1", count); end
    endtask

    task automatic test_reset_midframe();
        send_frame(8'h0F, 1'b0, 1'b1, HALF, 4, 1'b0);
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        clear_counts();
        @(negedge clk_sys);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_mid_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_mid_empty: got %b expected 1", empty); end
        send_frame(8'h81, 1'b0, 1'b1, HALF, 11, 1'b0);
        checks++; if (dout !== 8'h81) begin errors++; $display("FAIL rst_mid_dout: got %h expected 81", dout); end
        checks++; if (n_ferr != 0) begin errors++; $display("FAIL rst_mid_ferr: got %0d expected 0", n_ferr); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sequence();
        test_parity();
        test_stop_err();
        test_timeout();
        test_overflow();
        test_glitch();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
